// File: rtl/multi_edge_counter.sv
// Multi-channel gated edge counter: synchronised edge detection per channel, saturating
// counts over a fixed gate window, results published with a one-cycle valid strobe.
module multi_edge_counter #(
  parameter int NCH         = 4,
  parameter int CNT_W       = 8,
  parameter int SAT_MAX     = 250,
  parameter int GATE_CYCLES = 1000
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [1:0]           edge_mode,
  input  logic [NCH-1:0]       sig_in,
  output logic [NCH*CNT_W-1:0] data_out,
  output logic [NCH-1:0]       ovf,
  output logic                 data_valid,
  output logic                 busy
);

  localparam int               TMR_W    = $clog2(GATE_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(SAT_MAX);
  localparam logic [1:0]       ARM_LAST = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_RUN
  } state_t;

  state_t state, state_nxt;

  logic [NCH-1:0]            q1, q2, q3;
  logic [1:0]                mode;
  logic [1:0]                arm_cnt;
  logic [TMR_W-1:0]          timer;
  logic [NCH-1:0][CNT_W-1:0] cnt, cnt_nxt;
  logic [NCH-1:0]            win_ovf, sat_hit;
  logic [NCH-1:0]            rise, fall, edge_det;
  logic                      counting, terminal;

  // Edges are judged on q2/q3 only, so mode 11 yields at most one count per cycle.
  always_comb begin
    rise     = q2 & ~q3;
    fall     = ~q2 & q3;
    edge_det = ({NCH{mode[0]}} & rise) | ({NCH{mode[1]}} & fall);
  end

  assign counting = (state == S_RUN) && enable;
  assign terminal = counting && (timer == TMR_LAST);
  assign busy     = (state != S_IDLE);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    cnt_nxt = cnt;
    sat_hit = '0;
    for (int i = 0; i < NCH; i++) begin
      if (edge_det[i]) begin
        if (cnt[i] >= CNT_SAT) sat_hit[i] = 1'b1;
        else                   cnt_nxt[i] = cnt[i] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (enable) state_nxt = S_ARM;
      S_ARM:   if (!enable) state_nxt = S_IDLE;
               else if (arm_cnt == ARM_LAST) state_nxt = S_RUN;
      S_RUN:   if (!enable) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      q1         <= '0;
      q2         <= '0;
      q3         <= '0;
      mode       <= '0;
      arm_cnt    <= '0;
      timer      <= '0;
      cnt        <= '0;
      win_ovf    <= '0;
      data_out   <= '0;
      ovf        <= '0;
      data_valid <= 1'b0;
    end else begin
      q1         <= sig_in;
      q2         <= q1;
      q3         <= q2;
      data_valid <= 1'b0;

      // Mode is frozen for the whole busy period; later edge_mode changes wait for re-arm.
      if (state == S_IDLE && enable) mode <= edge_mode;

      arm_cnt <= (state == S_ARM) ? arm_cnt + 2'd1 : 2'd0;

      if (terminal) begin
        data_out   <= cnt_nxt;
        ovf        <= win_ovf | sat_hit;
        data_valid <= 1'b1;
        timer      <= '0;
        cnt        <= '0;
        win_ovf    <= '0;
      end else if (counting) begin
        timer   <= timer + TMR_W'(1);
        cnt     <= cnt_nxt;
        win_ovf <= win_ovf | sat_hit;
      end else begin
        // IDLE, ARM, or a window abandoned by enable=0: discard partial results.
        timer   <= '0;
        cnt     <= '0;
        win_ovf <= '0;
      end
    end
  end

endmodule

// File: tb/tb_multi_edge_counter.sv
// Self-checking bench for multi_edge_counter: cycle-level behavioural model plus directed
// scenarios with literal expectations, followed by a randomized phase.
module tb_multi_edge_counter;

  localparam int NCH     = 4;
  localparam int CNT_W   = 8;
  localparam int SAT_MAX = 250;
  localparam int GATE    = 1000;

  logic                 clk_in = 1'b0;
  logic                 reset;
  logic                 enable;
  logic [1:0]           edge_mode;
  logic [NCH-1:0]       sig_in;
  logic [NCH*CNT_W-1:0] data_out;
  logic [NCH-1:0]       ovf;
  logic                 data_valid;
  logic                 busy;

  int n_total = 0;
  int n_bad   = 0;

  multi_edge_counter #(
    .NCH(NCH), .CNT_W(CNT_W), .SAT_MAX(SAT_MAX), .GATE_CYCLES(GATE)
  ) dut (
    .clk_in(clk_in), .reset(reset), .enable(enable), .edge_mode(edge_mode),
    .sig_in(sig_in), .data_out(data_out), .ovf(ovf), .data_valid(data_valid), .busy(busy)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: tracks cycles since arming and counts raw (unsaturated) edges per
  // window; published value is min(raw, SAT_MAX) and overflow is raw > SAT_MAX.
  bit                   model_ok = 1'b0;
  bit                   m_active;
  int                   m_age;
  logic [1:0]           m_mode;
  int                   raw [NCH];
  logic [NCH-1:0]       hist [3];
  logic [NCH*CNT_W-1:0] exp_data;
  logic [NCH-1:0]       exp_ovf;
  logic                 exp_valid, exp_busy;

  always @(posedge clk_in) begin : model
    logic [NCH-1:0] moved;
    if (reset) begin
      model_ok  = 1'b1;
      m_active  = 1'b0;
      m_age     = 0;
      m_mode    = 2'b00;
      exp_data  = '0;
      exp_ovf   = '0;
      exp_valid = 1'b0;
      exp_busy  = 1'b0;
      for (int c = 0; c < NCH; c++) raw[c] = 0;
      for (int k = 0; k < 3; k++) hist[k] = '0;
    end else begin
      exp_valid = 1'b0;
      // Sample taken two clocks ago vs three clocks ago decides this clock's edge.
      moved = hist[1] ^ hist[2];
      if (!m_active) begin
        if (enable) begin
          m_active = 1'b1;
          m_age    = 0;
          m_mode   = edge_mode;
          for (int c = 0; c < NCH; c++) raw[c] = 0;
        end
      end else if (!enable) begin
        m_active = 1'b0;
      end else begin
        if (m_age >= 3) begin
          for (int c = 0; c < NCH; c++)
            if (moved[c] && (hist[1][c] ? m_mode[0] : m_mode[1])) raw[c]++;
          if ((m_age - 3) % GATE == GATE - 1) begin
            for (int c = 0; c < NCH; c++) begin
              exp_data[c*CNT_W +: CNT_W] = CNT_W'((raw[c] > SAT_MAX) ? SAT_MAX : raw[c]);
              exp_ovf[c] = (raw[c] > SAT_MAX);
              raw[c] = 0;
            end
            exp_valid = 1'b1;
          end
        end
        m_age++;
      end
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = sig_in;
      exp_busy = m_active;
    end
  end

  always @(negedge clk_in) begin
    if (model_ok)
      check("outputs_vs_model", 64'({data_out, ovf, data_valid, busy}),
            64'({exp_data, exp_ovf, exp_valid, exp_busy}));
  end

  // Pattern driver: periodic toggles per channel, or random toggles with per-channel rates.
  int period [NCH] = '{default: 0};
  bit rnd_on = 1'b0;
  int cyc = 0;

  initial forever begin
    @(negedge clk_in);
    #1;
    cyc++;
    for (int i = 0; i < NCH; i++) begin
      if (rnd_on) begin
        if ($urandom_range(0, (1 << (i + 1)) - 1) == 0) sig_in[i] = ~sig_in[i];
      end else if (period[i] != 0 && (cyc % period[i]) == 0) begin
        sig_in[i] = ~sig_in[i];
      end
    end
  end

  task automatic wait_strobe(output int n, input int limit);
    n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while (!data_valid && n < limit);
    check("strobe_seen", 64'(data_valid), 64'(1));
  endtask

  task automatic rearm(input logic [1:0] m);
    enable = 1'b0;
    repeat (3) @(negedge clk_in);
    enable    = 1'b1;
    edge_mode = m;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1);
  end

  initial begin
    int n;
    reset     = 1'b1;
    enable    = 1'b0;
    edge_mode = 2'b00;
    sig_in    = '1;
    repeat (3) @(negedge clk_in);
    check("reset_outputs", 64'({data_out, ovf, data_valid, busy}), 64'(0));

    // First window with no toggles: strobe after 1 + 3 + GATE clocks, all zero.
    reset     = 1'b0;
    enable    = 1'b1;
    edge_mode = 2'b01;
    wait_strobe(n, 1100);
    check("first_strobe_latency", 64'(n), 64'(1004));
    check("first_strobe_data", 64'({data_out, ovf}), 64'(0));

    // ch0 toggles every 10 clocks: 50 rises per full window.
    period[0] = 10;
    wait_strobe(n, 1100);
    wait_strobe(n, 1100);
    check("rise_count_ch0", 64'(data_out), 64'(32'h0000_0032));
    check("rise_ovf", 64'(ovf), 64'(0));

    rearm(2'b11);
    wait_strobe(n, 1100);
    check("both_count_ch0", 64'(data_out), 64'(32'h0000_0064));

    rearm(2'b10);
    repeat (200) @(negedge clk_in);
    edge_mode = 2'b11;
    wait_strobe(n, 1100);
    check("fall_count_mode_frozen", 64'(data_out), 64'(32'h0000_0032));

    rearm(2'b00);
    wait_strobe(n, 1100);
    check("mode00_count", 64'(data_out), 64'(0));

    // ch1 toggles every clock in mode 11: saturate and flag overflow.
    period[0] = 0;
    period[1] = 1;
    rearm(2'b11);
    wait_strobe(n, 1100);
    check("sat_count_ch1", 64'(data_out), 64'(32'h0000_FA00));
    check("sat_ovf_ch1", 64'(ovf), 64'(4'b0010));
    period[1] = 0;
    wait_strobe(n, 1100);
    check("pipeline_residue_ch1", 64'({data_out, ovf}), 64'({32'h0000_0200, 4'b0000}));
    wait_strobe(n, 1100);
    check("idle_window_ch1", 64'({data_out, ovf}), 64'(0));

    // Single rise on ch2 counted on the terminal cycle of a window.
    enable    = 1'b0;
    sig_in[2] = 1'b0;
    repeat (3) @(negedge clk_in);
    enable    = 1'b1;
    edge_mode = 2'b01;
    wait_strobe(n, 1100);
    check("pre_terminal_window", 64'(data_out), 64'(0));
    repeat (997) @(negedge clk_in);
    sig_in[2] = 1'b1;
    wait_strobe(n, 1100);
    check("terminal_edge_latency", 64'(n), 64'(3));
    check("terminal_edge_closing", 64'(data_out), 64'(32'h0001_0000));
    wait_strobe(n, 1100);
    check("terminal_edge_next", 64'(data_out), 64'(0));

    // Abort a window mid-way, then re-arm and reset on a terminal cycle.
    period[0] = 10;
    rearm(2'b01);
    wait_strobe(n, 1100);
    check("abort_prev_window", 64'(data_out), 64'(32'h0000_0032));
    repeat (500) @(negedge clk_in);
    enable = 1'b0;
    @(negedge clk_in);
    check("abort_busy_low", 64'(busy), 64'(0));
    repeat (20) @(negedge clk_in);
    check("abort_data_held", 64'({data_out, ovf}), 64'({32'h0000_0032, 4'b0000}));
    enable = 1'b1;
    wait_strobe(n, 1100);
    check("rearm_latency", 64'(n), 64'(1004));
    check("rearm_data", 64'(data_out), 64'(32'h0000_0032));
    repeat (999) @(negedge clk_in);
    reset  = 1'b1;
    enable = 1'b0;
    @(negedge clk_in);
    check("reset_on_terminal", 64'({data_out, ovf, data_valid, busy}), 64'(0));
    reset     = 1'b0;
    period[0] = 0;

    // Randomized traffic with random window lengths, mode changes and aborts.
    rnd_on = 1'b1;
    for (int k = 0; k < 8; k++) begin
      int len;
      edge_mode = 2'($urandom);
      enable    = 1'b1;
      len       = (k % 3 == 2) ? int'($urandom_range(1, 6)) : int'($urandom_range(1500, 2600));
      for (int j = 0; j < len; j++) begin
        @(negedge clk_in);
        if ($urandom_range(0, 499) == 0) edge_mode = 2'($urandom);
        if (k == 5 && j == 1200) reset = 1'b1;
        else reset = 1'b0;
      end
      reset  = 1'b0;
      enable = 1'b0;
      repeat ($urandom_range(1, 4)) @(negedge clk_in);
    end
    rnd_on = 1'b0;
    repeat (5) @(negedge clk_in);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
